// File: rtl/ffe_coef_ctrl_pkg.sv
// Shared definitions for the FFE coefficient controller: default sizes,
// the controller state enum and the unity-gain tap value.
package ffe_pkg;

   localparam int COEF_BW_DEF    = 9;
   localparam int N_COEF_DEF     = 7;
   localparam int ADDR_BW_DEF    = 3;
   localparam int CENTER_TAP_DEF = 3;

   // Unity gain at the FFE output scaling is 2^(COEF_BW-2).
   localparam int UNITY_DEF = 2 ** (COEF_BW_DEF - 2);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      UPDATE      = 2'd1,
      COMMIT_WAIT = 2'd2
   } state_e;

   // Unity tap value for an arbitrary coefficient width.
   function automatic int unity_of(input int bw);
      return 1 << (bw - 2);
   endfunction

endpackage

// File: rtl/ffe_coef_ctrl_sat_add.sv
// Combinational signed add of a tap and its LMS delta.
// Build option FFE_COEF_CTRL_SAT_EN: when defined the sum is formed one bit
// wider and clamped to the signed W-bit range; otherwise it wraps modulo 2^W.
module ffe_coef_sat_add #(
   parameter int W = 9
) (
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic signed [W-1:0] sum_o
);

`ifdef FFE_COEF_CTRL_SAT_EN
   // Sign-extended add; the two top bits disagree only on overflow.
   function automatic logic signed [W-1:0] tap_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
      logic signed [W:0] s;
      s = $signed({a[W-1], a}) + $signed({b[W-1], b});
      if (s[W] != s[W-1])
         tap_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         tap_add = s[W-1:0];
   endfunction
`else
   // Plain two's complement add; overflow wraps.
   function automatic logic signed [W-1:0] tap_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
      tap_add = a + b;
   endfunction
`endif

   assign sum_o = tap_add(a_i, b_i);

endmodule

// File: rtl/ffe_coef_ctrl.sv
// FFE coefficient controller. Host writes and LMS delta vectors land in a
// shadow bank (deltas applied one tap per cycle); a commit copies the shadow
// bank into the active bank on an i_en boundary so the FFE never sees a
// partially updated tap set. Build option FFE_COEF_CTRL_SAT_EN selects
// saturating instead of wrapping tap updates (see ffe_coef_sat_add).
module ffe_coef_ctrl
   import ffe_pkg::*;
#(
   parameter int COEF_BW    = COEF_BW_DEF,
   parameter int N_COEF     = N_COEF_DEF,
   parameter int ADDR_BW    = ADDR_BW_DEF,
   parameter int CENTER_TAP = CENTER_TAP_DEF
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_en,
   input  logic                        i_wr_valid,
   output logic                        o_wr_ready,
   input  logic [ADDR_BW-1:0]          i_wr_addr,
   input  logic [COEF_BW-1:0]          i_wr_data,
   input  logic                        i_upd_valid,
   output logic                        o_upd_ready,
   input  logic [COEF_BW*N_COEF-1:0]   i_upd_delta,
   input  logic                        i_commit,
   output logic [COEF_BW*N_COEF-1:0]   o_coefs,
   output logic                        o_swap,
   output logic                        o_busy
);

   localparam logic signed [COEF_BW-1:0] UNITY    = COEF_BW'(unity_of(COEF_BW));
   localparam logic [ADDR_BW-1:0]        LAST_TAP = ADDR_BW'(N_COEF - 1);

   state_e                     state_q, state_d;
   logic                       pend_q, pend_d;
   logic                       swap_q, swap_d;
   logic                       busy_q;
   logic [ADDR_BW-1:0]         cnt_q;
   logic signed [COEF_BW-1:0]  shadow_q [N_COEF];
   logic signed [COEF_BW-1:0]  active_q [N_COEF];
   logic signed [COEF_BW-1:0]  delta_q  [N_COEF];
   logic signed [COEF_BW-1:0]  tap_sum;
   logic                       wr_acc, upd_acc, wr_in_range, last_tap;

   assign o_wr_ready  = (state_q == IDLE);
   assign o_upd_ready = (state_q == IDLE) && !i_wr_valid;
   assign wr_acc      = i_wr_valid && o_wr_ready;
   assign upd_acc     = i_upd_valid && o_upd_ready;
   assign wr_in_range = (int'(i_wr_addr) < N_COEF);
   assign last_tap    = (cnt_q == LAST_TAP);

   // Tap currently being walked: shadow[k] + delta[k]
   ffe_coef_sat_add #(.W(COEF_BW)) u_sat_add (
      .a_i   (shadow_q[cnt_q]),
      .b_i   (delta_q[cnt_q]),
      .sum_o (tap_sum)
   );

   // Next-state, commit-pending and swap decisions
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      swap_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // An update accepted together with a commit must finish its
            // walk before the swap, so the commit is parked as pending.
            if (upd_acc) begin
               state_d = UPDATE;
               pend_d  = i_commit;
            end else if (i_commit) begin
               state_d = COMMIT_WAIT;
            end
         end
         UPDATE: begin
            if (i_commit)
               pend_d = 1'b1;
            if (last_tap)
               state_d = (pend_q || i_commit) ? COMMIT_WAIT : IDLE;
         end
         COMMIT_WAIT: begin
            if (i_en) begin
               state_d = IDLE;
               pend_d  = 1'b0;
               swap_d  = 1'b1;
            end else if (i_commit) begin
               pend_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            pend_d  = 1'b0;
         end
      endcase
   end

   // Control registers: state, tap counter, pending flag, registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         swap_q  <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         swap_q  <= swap_d;
         busy_q  <= (state_d != IDLE);
         if (upd_acc)
            cnt_q <= '0;
         else if (state_q == UPDATE)
            cnt_q <= cnt_q + ADDR_BW'(1);
      end
   end

   // Coefficient banks and latched delta vector
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < N_COEF; k++) begin
            shadow_q[k] <= (k == CENTER_TAP) ? UNITY : '0;
            active_q[k] <= (k == CENTER_TAP) ? UNITY : '0;
            delta_q[k]  <= '0;
         end
      end else begin
         // Out-of-range host addresses are handshaked but dropped.
         if (wr_acc && wr_in_range)
            shadow_q[i_wr_addr] <= i_wr_data;
         if (upd_acc)
            for (int k = 0; k < N_COEF; k++)
               delta_q[k] <= i_upd_delta[k*COEF_BW +: COEF_BW];
         if (state_q == UPDATE)
            shadow_q[cnt_q] <= tap_sum;
         if (swap_d)
            for (int k = 0; k < N_COEF; k++)
               active_q[k] <= shadow_q[k];
      end
   end

   for (genvar g = 0; g < N_COEF; g++) begin : g_pack
      assign o_coefs[g*COEF_BW +: COEF_BW] = active_q[g];
   end

   assign o_swap = swap_q;
   assign o_busy = busy_q;

endmodule

// File: tb/tb_ffe_coef_ctrl.sv
// Bench for ffe_coef_ctrl: directed scenarios with literal expectations plus
// a cycle-level behavioural model compared against the outputs every cycle.
module tb_ffe_coef_ctrl;

   localparam int BW = 9;
   localparam int N  = 7;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           en = 1'b0;
   logic           wr_valid = 1'b0;
   logic           wr_ready;
   logic [2:0]     wr_addr = '0;
   logic [BW-1:0]  wr_data = '0;
   logic           upd_valid = 1'b0;
   logic           upd_ready;
   logic [BW*N-1:0] upd_delta = '0;
   logic           commit = 1'b0;
   logic [BW*N-1:0] coefs;
   logic           swap;
   logic           busy;

   int checks = 0;
   int failures = 0;
   int swap_cnt = 0;
   bit model_on = 1'b0;

   ffe_coef_ctrl dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_wr_valid  (wr_valid),
      .o_wr_ready  (wr_ready),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .i_upd_valid (upd_valid),
      .o_upd_ready (upd_ready),
      .i_upd_delta (upd_delta),
      .i_commit    (commit),
      .o_coefs     (coefs),
      .o_swap      (swap),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int  m_shadow [N];
   int  m_active [N];
   int  m_delta  [N];
   int  m_left;      // taps still to walk
   int  m_idx;
   bit  m_want;      // a commit has been requested and not yet swapped
   bit  m_swap;

   function automatic int fold(input int s);
`ifdef FFE_COEF_CTRL_SAT_EN
      if (s > 255) return 255;
      if (s < -256) return -256;
      return s;
`else
      int r;
      r = s & 511;
      if (r > 255) r = r - 512;
      return r;
`endif
   endfunction

   function automatic int dval(input logic [BW*N-1:0] v, input int k);
      logic signed [BW-1:0] t;
      t = v[k*BW +: BW];
      return int'(t);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_shadow[k] = (k == 3) ? 128 : 0;
         m_active[k] = (k == 3) ? 128 : 0;
         m_delta[k]  = 0;
      end
      m_left = 0; m_idx = 0; m_want = 0; m_swap = 0;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset();
      end else begin
         bit idle_old;
         bit want_old;
         idle_old = (m_left == 0) && !m_want;
         want_old = m_want;
         m_swap = (m_left == 0) && want_old && en;
         if (m_swap) begin
            for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
            m_want = 0;
         end else if (commit) begin
            m_want = 1;
         end
         if (m_left > 0) begin
            m_shadow[m_idx] = fold(m_shadow[m_idx] + m_delta[m_idx]);
            m_idx++;
            m_left--;
         end else if (idle_old && wr_valid) begin
            if (int'(wr_addr) < N) m_shadow[int'(wr_addr)] = dval({{(BW*N-BW){1'b0}}, wr_data}, 0);
         end else if (idle_old && upd_valid) begin
            for (int k = 0; k < N; k++) m_delta[k] = dval(upd_delta, k);
            m_left = N;
            m_idx = 0;
         end
      end
   end

   // ---------------- checking helpers ----------------
   function automatic int tap(input int k);
      return dval(coefs, k);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst && model_on) begin
         bit mbusy;
         mbusy = (m_left > 0) || m_want;
         for (int k = 0; k < N; k++) check($sformatf("model_tap%0d", k), tap(k), m_active[k]);
         check("model_swap", int'(swap), int'(m_swap));
         check("model_busy", int'(busy), int'(mbusy));
         check("model_wr_ready", int'(wr_ready), int'(!mbusy));
         check("model_upd_ready", int'(upd_ready), int'(!mbusy && !wr_valid));
      end
   end

   always @(negedge clk) if (!rst && swap) swap_cnt++;

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 0; wr_valid = 0; upd_valid = 0; commit = 0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic host_write(input int addr, input int data);
      wr_valid = 1; wr_addr = 3'(addr); wr_data = BW'(data);
      tick();
      wr_valid = 0;
   endtask

   task automatic upd_all(input int d);
      for (int k = 0; k < N; k++) upd_delta[k*BW +: BW] = BW'(d);
   endtask

   task automatic wait_idle(input string name, output int n);
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         failures++;
         checks++;
         $display("FAIL %s: busy timeout after %0d cycles", name, n);
      end
   endtask

   task automatic commit_and_swap();
      commit = 1; tick(); commit = 0;
      en = 1; tick(); en = 0;
      tick();
   endtask

   int n;
   int sc0;
   int exp_reset [N] = '{0, 0, 0, 128, 0, 0, 0};
   int exp_walk  [N] = '{1, 1, 1, 129, 1, 1, 1};
   int exp_neg   [N] = '{-1, -1, -1, 127, -1, -1, -1};

   initial begin
      #2 rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      model_on = 1'b1;

      // Reset state
      for (int k = 0; k < N; k++) check($sformatf("reset_tap%0d", k), tap(k), exp_reset[k]);
      check("reset_swap", int'(swap), 0);
      check("reset_busy", int'(busy), 0);

      // Write then commit with i_en held low
      host_write(2, -5);
      commit = 1; tick(); commit = 0;
      sc0 = swap_cnt;
      repeat (10) tick();
      check("hold_tap2", tap(2), 0);
      check("hold_busy", int'(busy), 1);
      en = 1; tick(); en = 0;
      check("swap_pulse", int'(swap), 1);
      check("swap_tap2", tap(2), -5);
      tick();
      check("swap_one_cycle", int'(swap), 0);
      check("swap_count", swap_cnt - sc0, 1);

      // Update walk from reset with all deltas +1
      do_reset();
      upd_all(1);
      upd_valid = 1; tick(); upd_valid = 0;
      wait_idle("walk", n);
      check("walk_cycles", n, 7);
      commit_and_swap();
      for (int k = 0; k < N; k++) check($sformatf("walk_tap%0d", k), tap(k), exp_walk[k]);

      // Overflow of tap 0: 255 + 10
      do_reset();
      host_write(0, 255);
      upd_delta = '0; upd_delta[0 +: BW] = BW'(10);
      upd_valid = 1; tick(); upd_valid = 0;
      wait_idle("sat", n);
      commit_and_swap();
`ifdef FFE_COEF_CTRL_SAT_EN
      check("sat_tap0", tap(0), 255);
`else
      check("wrap_tap0", tap(0), -247);
`endif
      check("sat_tap3", tap(3), 128);

      // Arbitration: host write wins, update follows next cycle
      wr_valid = 1; wr_addr = 3'd5; wr_data = BW'(7);
      upd_delta = '0; upd_delta[5*BW +: BW] = BW'(2);
      upd_valid = 1;
      #1;
      check("arb_wr_ready", int'(wr_ready), 1);
      check("arb_upd_ready", int'(upd_ready), 0);
      tick();
      wr_valid = 0;
      #1;
      check("arb_upd_ready_next", int'(upd_ready), 1);
      tick();
      upd_valid = 0;
      check("arb_busy", int'(busy), 1);
      wait_idle("arb", n);
      commit_and_swap();
      check("arb_tap5", tap(5), 9);

      // Out-of-range write is dropped
      host_write(7, 33);
      commit_and_swap();
      check("oob_tap5", tap(5), 9);

      // Commit during the walk, i_en held high through the end
      do_reset();
      upd_all(-1);
      upd_valid = 1; tick(); upd_valid = 0;
      tick();
      commit = 1; tick(); commit = 0;
      sc0 = swap_cnt;
      repeat (10) tick();
      check("cdu_busy_wait", int'(busy), 1);
      check("cdu_no_swap_yet", swap_cnt - sc0, 0);
      en = 1; repeat (4) tick(); en = 0;
      tick();
      check("cdu_swap_count", swap_cnt - sc0, 1);
      check("cdu_busy_done", int'(busy), 0);
      for (int k = 0; k < N; k++) check($sformatf("cdu_tap%0d", k), tap(k), exp_neg[k]);

      // Asynchronous reset in the middle of a walk
      upd_all(3);
      upd_valid = 1; tick(); upd_valid = 0;
      tick();
      #2 rst = 1'b1;
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_tap0", tap(0), 0);
      check("arst_tap3", tap(3), 128);
      tick();
      rst = 1'b0;
      commit_and_swap();
      for (int k = 0; k < N; k++) check($sformatf("arst_shadow_tap%0d", k), tap(k), exp_reset[k]);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ffe_coef_ctrl.md
# ffe_coef_ctrl

Coefficient controller for the feed-forward equalizer. It owns a shadow and an active coefficient bank and drives the FFE flat coefficient bus from the active bank. Host writes and LMS delta updates are arbitrated into the shadow bank; LMS deltas are applied one tap per cycle. A commit copies shadow to active atomically on a symbol-enable boundary, so the FFE never sees a half-updated tap set.

## Interface
- COEF_BW, 9, coefficient width (signed, two's complement)
- N_COEF, 7, number of taps
- ADDR_BW, 3, tap address width; requires 2^ADDR_BW >= N_COEF
- CENTER_TAP, 3, tap index loaded with unity at reset
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  1  FFE symbol enable; the same strobe that drives the FFE
- i_wr_valid  in  1  host write request
- o_wr_ready  out  1  host write accepted this cycle when high together with i_wr_valid
- i_wr_addr  in  ADDR_BW  tap index
- i_wr_data  in  COEF_BW  signed tap value
- i_upd_valid  in  1  LMS delta vector valid
- o_upd_ready  out  1  delta vector accepted when high together with i_upd_valid
- i_upd_delta  in  COEF_BW*N_COEF  signed deltas, packed tap N-1 (MSBs) down to tap 0 (LSBs)
- i_commit  in  1  single-cycle commit request pulse
- o_coefs  out  COEF_BW*N_COEF  active bank, same packing; connects to the FFE coefficient bus
- o_swap  out  1  one-cycle pulse, registered on the edge where the active bank loads
- o_busy  out  1  high whenever state is not IDLE

## Operation
- Reset: both banks hold tap CENTER_TAP = 2^(COEF_BW-2) (128 for COEF_BW=9, unity gain at the FFE output scaling) and all other taps = 0.
- Reset: state = IDLE, o_swap = 0, commit-pending = 0, delta register = 0, o_busy = 0.
- Reset asserted mid-operation aborts any update or commit immediately.
- States: IDLE, UPDATE, COMMIT_WAIT.
- IDLE arbitration: host has fixed priority.
  - o_wr_ready = (state == IDLE).
  - o_upd_ready = (state == IDLE) && !i_wr_valid.
- Host write: shadow[i_wr_addr] <= i_wr_data.
  - An address >= N_COEF is accepted and dropped; no bank changes.
- Update accept, IDLE -> UPDATE: latch i_upd_delta and reset the tap counter to 0.
- UPDATE: each cycle shadow[k] <= shadow[k] + delta[k], then k++.
  - After the cycle that writes tap N_COEF-1, go to COMMIT_WAIT if commit-pending, otherwise to IDLE.
- Commit:
  - i_commit in IDLE goes to COMMIT_WAIT. A write or update accepted on the same edge is still performed and is included in the commit.
  - i_commit in UPDATE or COMMIT_WAIT sets commit-pending. Multiple requests collapse into one.
- COMMIT_WAIT: on the first edge with i_en = 1, active <= shadow, o_swap <= 1, commit-pending <= 0, go to IDLE.
  - i_en coincident with the i_commit edge in IDLE does not count; the swap happens on the next i_en.
- Shadow contents persist after a commit; they are not cleared.

## Timing
- Host write accepted at edge t: shadow is updated at t. It is visible on o_coefs only after a commit.
- Update accepted at edge t: taps 0..N-1 are written at edges t+1..t+N. o_upd_ready and o_wr_ready can return high in the cycle after edge t+N.
- Swap at edge t: o_coefs and o_swap change after t. o_swap is high for exactly one cycle.
- The FFE uses the new taps starting with the sample it captures on the next i_en.
- o_busy is registered and equals (state != IDLE).

## Configuration
- FFE_COEF_CTRL_SAT_EN defined: the tap sum is computed at COEF_BW+1 bits and saturated to [-2^(COEF_BW-1), 2^(COEF_BW-1)-1].
- Not defined: the sum wraps modulo 2^COEF_BW, saving the comparator logic.
- Host writes are unaffected in both cases.

## Structure
- Shared package ffe_pkg holds:
  - default COEF_BW, N_COEF, ADDR_BW, CENTER_TAP;
  - the state enum (IDLE, UPDATE, COMMIT_WAIT);
  - the unity constant 2^(COEF_BW-2).
- One sub-module, ffe_coef_sat_add: a combinational signed add with optional saturation under FFE_COEF_CTRL_SAT_EN. It is reusable by the LMS error path.

## Test plan
- Reset check: after reset, o_coefs has tap 3 = 128 and all other taps = 0; o_swap = 0 and o_busy = 0.
- Write then commit:
  - Write tap 2 = -5, then pulse i_commit with i_en held low for 10 cycles: o_coefs is unchanged and o_busy = 1.
  - i_en high: one o_swap pulse and tap 2 = -5.
- Update walk: from reset, delta vector all +1 -> exactly 7 UPDATE cycles. After commit, the taps read 1,1,1,129,1,1,1.
- Saturation: tap 0 = 255, delta +10.
  - With FFE_COEF_CTRL_SAT_EN: 255 after commit.
  - Without it: -247.
- Arbitration: i_wr_valid and i_upd_valid both high in IDLE -> the write is accepted first and o_upd_ready = 0. The update is accepted in the next cycle.
- Commit during UPDATE: i_commit at update cycle 2 -> the walk completes, goes to COMMIT_WAIT, and exactly one swap happens on the next i_en.
- Async reset during UPDATE: o_busy drops with no clock edge, and the banks return to their reset values.
